// File: rtl/mult_sweep_scorer.sv
// mult_sweep_scorer
//   Walks every operand pair of a combinational WIDTH x WIDTH multiplier,
//   compares the returned product with the exact product and scores the
//   result: mismatch count, first mismatching pair and largest absolute error.
//
// Ports
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   start           in   request one exhaustive sweep (sampled in IDLE only)
//   busy            out  sweep running (DRIVE/SAMPLE)
//   done            out  one-cycle pulse in DONE
//   dut_a, dut_b    out  operands to the multiplier under test
//   dut_p           in   product returned by the multiplier under test
//   err_count       out  number of mismatching pairs (never saturates)
//   first_err_valid out  at least one mismatch recorded
//   first_err_a/b   out  operands of the lowest-index mismatching pair
//   max_abs_err     out  largest |dut_p - A*B|
//   sum_abs_err     out  sum of |dut_p - A*B| (only with ABS_ERR_SUM_EN)
//
// Build option
//   ABS_ERR_SUM_EN  when defined, adds the sum_abs_err port and accumulator.

module mult_sweep_scorer #(
  parameter int WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  input  logic [2*WIDTH-1:0]   dut_p,
  output logic [2*WIDTH:0]     err_count,
  output logic                 first_err_valid,
  output logic [WIDTH-1:0]     first_err_a,
  output logic [WIDTH-1:0]     first_err_b,
  output logic [2*WIDTH-1:0]   max_abs_err
`ifdef ABS_ERR_SUM_EN
  ,
  output logic [4*WIDTH-1:0]   sum_abs_err
`endif
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Unsigned absolute difference; never overflows at PW bits.
  function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] x,
                                             input logic [PW-1:0] y);
    if (x >= y) begin
      abs_diff = x - y;
    end else begin
      abs_diff = y - x;
    end
  endfunction

  state_t             state_r, state_s;
  logic [PW-1:0]      idx_r, idx_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic [WIDTH-1:0]   dut_a_r, dut_a_s;
  logic [WIDTH-1:0]   dut_b_r, dut_b_s;
  logic [PW:0]        err_r, err_s;
  logic               fev_r, fev_s;
  logic [WIDTH-1:0]   fea_r, fea_s;
  logic [WIDTH-1:0]   feb_r, feb_s;
  logic [PW-1:0]      max_r, max_s;
  logic [PW-1:0]      prod_s;
  logic [PW-1:0]      diff_s;
`ifdef ABS_ERR_SUM_EN
  logic [4*WIDTH-1:0] sum_r, sum_s;
`endif

  // Exact product of the pair currently on the operand bus, zero-extended.
  always_comb begin
    prod_s = {{WIDTH{1'b0}}, idx_r[PW-1:WIDTH]} * {{WIDTH{1'b0}}, idx_r[WIDTH-1:0]};
    diff_s = abs_diff(dut_p, prod_s);
  end

  // Next-state, scoring and registered-output decode.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    err_s   = err_r;
    fev_s   = fev_r;
    fea_s   = fea_r;
    feb_s   = feb_r;
    max_s   = max_r;
`ifdef ABS_ERR_SUM_EN
    sum_s   = sum_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = DRIVE;
          idx_s   = '0;
          err_s   = '0;
          fev_s   = 1'b0;
          fea_s   = '0;
          feb_s   = '0;
          max_s   = '0;
`ifdef ABS_ERR_SUM_EN
          sum_s   = '0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      DRIVE: begin
        state_s = SAMPLE;
      end
      SAMPLE: begin
        if (diff_s != {PW{1'b0}}) begin
          err_s = err_r + {{PW{1'b0}}, 1'b1};
          if (!fev_r) begin
            fev_s = 1'b1;
            fea_s = idx_r[PW-1:WIDTH];
            feb_s = idx_r[WIDTH-1:0];
          end else begin
            fev_s = fev_r;
          end
          if (diff_s > max_r) begin
            max_s = diff_s;
          end else begin
            max_s = max_r;
          end
        end else begin
          err_s = err_r;
        end
`ifdef ABS_ERR_SUM_EN
        sum_s = sum_r + {{(4*WIDTH-PW){1'b0}}, diff_s};
`endif
        // Wraps to zero after the last pair; harmless since DONE/IDLE ignore idx.
        idx_s = idx_r + {{(PW-1){1'b0}}, 1'b1};
        if (idx_r == {PW{1'b1}}) begin
          state_s = DONE;
        end else begin
          state_s = DRIVE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s == DRIVE) || (state_s == SAMPLE);
    done_s = (state_s == DONE);
    if (busy_s) begin
      dut_a_s = idx_s[PW-1:WIDTH];
      dut_b_s = idx_s[WIDTH-1:0];
    end else begin
      dut_a_s = '0;
      dut_b_s = '0;
    end
  end

  // State, index, scoring results and outputs; all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dut_a_r <= '0;
      dut_b_r <= '0;
      err_r   <= '0;
      fev_r   <= 1'b0;
      fea_r   <= '0;
      feb_r   <= '0;
      max_r   <= '0;
`ifdef ABS_ERR_SUM_EN
      sum_r   <= '0;
`endif
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      dut_a_r <= dut_a_s;
      dut_b_r <= dut_b_s;
      err_r   <= err_s;
      fev_r   <= fev_s;
      fea_r   <= fea_s;
      feb_r   <= feb_s;
      max_r   <= max_s;
`ifdef ABS_ERR_SUM_EN
      sum_r   <= sum_s;
`endif
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign dut_a           = dut_a_r;
  assign dut_b           = dut_b_r;
  assign err_count       = err_r;
  assign first_err_valid = fev_r;
  assign first_err_a     = fea_r;
  assign first_err_b     = feb_r;
  assign max_abs_err     = max_r;
`ifdef ABS_ERR_SUM_EN
  assign sum_abs_err     = sum_r;
`endif

endmodule
